// File: rtl/cpm_sel_gen_pkg.sv
// Shared CPM definitions: the generator state encoding and the index-width helper.
package cpm_sel_gen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } cpm_state_e;

  // Never narrower than one bit, so DW=2 still yields a usable index.
  function automatic int cpm_aw(input int dw);
    return (dw <= 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/cpm_sel_gen_if.sv
// Request (index/length) and beat (one-hot select) handshakes of the CPM select generator.
interface cpm_sel_gen_if
  import cpm_sel_gen_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = cpm_aw(DW),
  parameter int LW = 4
);

  logic          IDX_VLD;
  logic          IDX_RDY;
  logic [AW-1:0] IDX;
  logic [LW-1:0] LEN;
  logic          SEL_VLD;
  logic          SEL_RDY;
  logic [DW-1:0] SEL;
  logic          SEL_LAST;
  logic          ERR;

  modport master (
    output IDX_VLD, IDX, LEN, SEL_RDY,
    input  IDX_RDY, SEL_VLD, SEL, SEL_LAST, ERR
  );

  modport slave (
    input  IDX_VLD, IDX, LEN, SEL_RDY,
    output IDX_RDY, SEL_VLD, SEL, SEL_LAST, ERR
  );

endinterface

// File: rtl/cpm_onehot_dec.sv
// Combinational lane decoder: index plus enable to one-hot; out-of-range indices give zero.
module cpm_onehot_dec #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic [AW-1:0] idx,
  input  logic          en,
  output logic [DW-1:0] onehot
);

  // Comparing against each lane keeps indices at or beyond DW from setting any bit.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < DW; i++) begin
      onehot[i] = en && (idx == AW'(i));
    end
  end

endmodule

// File: rtl/cpm_sel_gen.sv
// CPM select generator: turns a start index and burst length into a registered stream of
// one-hot lane selects that walks consecutive lanes with modulo-DW wrap.
module cpm_sel_gen
  import cpm_sel_gen_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = cpm_aw(DW),
  parameter int LW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cpm_sel_gen_if.slave bus
);

  localparam logic [AW:0]   DW_EXT    = (AW + 1)'(DW);
  localparam logic [AW-1:0] LAST_LANE = AW'(DW - 1);

  cpm_state_e    state, state_nxt;
  logic [AW-1:0] cur, cur_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] sel_q, sel_nxt;
  logic          last_q;
  logic          err_q, err_nxt;
  logic          idx_ok;

  assign idx_ok = {1'b0, bus.IDX} < DW_EXT;

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.IDX_VLD) begin
          if (idx_ok) begin
            state_nxt = ISSUE;
            cur_nxt   = bus.IDX;
            cnt_nxt   = bus.LEN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.SEL_RDY) begin
          if (cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - LW'(1);
            cur_nxt = (cur == LAST_LANE) ? '0 : cur + AW'(1);
          end
        end
      end
    endcase
  end

  // Decoding the next lane lets SEL come straight from a flop, aligned with SEL_VLD.
  cpm_onehot_dec #(
    .DW(DW),
    .AW(AW)
  ) u_dec (
    .idx    (cur_nxt),
    .en     (state_nxt == ISSUE),
    .onehot (sel_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur    <= '0;
      cnt    <= '0;
      sel_q  <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cur    <= cur_nxt;
      cnt    <= cnt_nxt;
      sel_q  <= sel_nxt;
      last_q <= (state_nxt == ISSUE) && (cnt_nxt == '0);
      err_q  <= err_nxt;
    end
  end

  assign bus.IDX_RDY  = (state == IDLE);
  assign bus.SEL_VLD  = (state == ISSUE);
  assign bus.SEL      = sel_q;
  assign bus.SEL_LAST = last_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_cpm_sel_gen.sv
// Bench for cpm_sel_gen: a queue model of expected beats checks a DW=8 instance every cycle,
// and a DW=6 instance covers the out-of-range rejection.
module tb_cpm_sel_gen;

  typedef struct {
    logic [7:0] sel;
    logic       last;
  } beat_t;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] len;
    logic [7:0] expFirst;
    logic [7:0] expLast;
    int         expBeats;
  } vec_t;

  logic clk;
  logic rst_n;

  int totalChecks = 0;
  int badChecks   = 0;

  beat_t      q[$];
  logic       expErr;
  int         beatCount;
  int         vldCycles;
  logic [7:0] firstSel;
  logic [7:0] lastSel;
  vec_t       vecs[6];

  cpm_sel_gen_if #(.DW(8), .AW(3), .LW(4)) bus8 ();
  cpm_sel_gen_if #(.DW(6), .AW(3), .LW(4)) bus6 ();

  cpm_sel_gen #(.DW(8), .AW(3), .LW(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  cpm_sel_gen #(.DW(6), .AW(3), .LW(4)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, compare against the model, advance one clock, update model.
  task automatic applyStimulus(input logic vld, input logic [2:0] idx, input logic [3:0] len,
                               input logic rdy);
    logic expVld;
    logic consume;
    logic accept;
    bus8.IDX_VLD = vld;
    bus8.IDX     = idx;
    bus8.LEN     = len;
    bus8.SEL_RDY = rdy;
    expVld = (q.size() != 0);
    checkOutput("idx_rdy", 32'(bus8.IDX_RDY), 32'(!expVld));
    checkOutput("sel_vld", 32'(bus8.SEL_VLD), 32'(expVld));
    checkOutput("err", 32'(bus8.ERR), 32'(expErr));
    checkOutput("onehot", 32'($countones(bus8.SEL)), expVld ? 32'd1 : 32'd0);
    if (expVld) begin
      checkOutput("sel", 32'(bus8.SEL), 32'(q[0].sel));
      checkOutput("sel_last", 32'(bus8.SEL_LAST), 32'(q[0].last));
      vldCycles++;
    end else begin
      checkOutput("sel_idle", 32'(bus8.SEL), 32'd0);
      checkOutput("sel_last_idle", 32'(bus8.SEL_LAST), 32'd0);
    end
    consume = expVld && rdy;
    accept  = !expVld && vld;
    if (consume) begin
      beatCount++;
      if (beatCount == 1) firstSel = q[0].sel;
      lastSel = q[0].sel;
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      expErr = 1'b0;
    end else begin
      if (consume) void'(q.pop_front());
      expErr = accept && (int'(idx) >= 8);
      if (accept && int'(idx) < 8) begin
        for (int b = 0; b <= int'(len); b++) begin
          beat_t nb;
          nb.sel  = 8'(1 << ((int'(idx) + b) % 8));
          nb.last = (b == int'(len));
          q.push_back(nb);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic runBurst(input logic [2:0] idx, input logic [3:0] len, input logic rdy);
    int guard;
    beatCount = 0;
    vldCycles = 0;
    firstSel  = '0;
    lastSel   = '0;
    applyStimulus(1'b1, idx, len, rdy);
    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
      guard++;
    end
    checkOutput("burst_drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{idx: 3'd3, len: 4'd0,  expFirst: 8'h08, expLast: 8'h08, expBeats: 1};
    vecs[1] = '{idx: 3'd6, len: 4'd3,  expFirst: 8'h40, expLast: 8'h02, expBeats: 4};
    vecs[2] = '{idx: 3'd6, len: 4'd9,  expFirst: 8'h40, expLast: 8'h80, expBeats: 10};
    vecs[3] = '{idx: 3'd0, len: 4'd15, expFirst: 8'h01, expLast: 8'h80, expBeats: 16};
    vecs[4] = '{idx: 3'd7, len: 4'd1,  expFirst: 8'h80, expLast: 8'h01, expBeats: 2};
    vecs[5] = '{idx: 3'd2, len: 4'd7,  expFirst: 8'h04, expLast: 8'h02, expBeats: 8};

    rst_n        = 1'b0;
    expErr       = 1'b0;
    bus8.IDX_VLD = 1'b0;
    bus8.IDX     = '0;
    bus8.LEN     = '0;
    bus8.SEL_RDY = 1'b0;
    bus6.IDX_VLD = 1'b0;
    bus6.IDX     = '0;
    bus6.LEN     = '0;
    bus6.SEL_RDY = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      runBurst(vecs[v].idx, vecs[v].len, 1'b1);
      checkOutput($sformatf("vec%0d_beats", v), 32'(beatCount), 32'(vecs[v].expBeats));
      checkOutput($sformatf("vec%0d_first", v), 32'(firstSel), 32'(vecs[v].expFirst));
      checkOutput($sformatf("vec%0d_last", v), 32'(lastSel), 32'(vecs[v].expLast));
      applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    end

    // Backpressure: second beat held three cycles before acceptance.
    vldCycles = 0;
    applyStimulus(1'b1, 3'd1, 4'd2, 1'b1);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
    repeat (3) applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkOutput("bp_beat_cycles", 32'(vldCycles), 32'd6);

    // Reset while the fourth beat is on the bus.
    applyStimulus(1'b1, 3'd0, 4'd15, 1'b1);
    repeat (3) applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);

    // Out-of-range index on the six-lane instance, then an immediate valid request.
    bus6.IDX_VLD = 1'b1;
    bus6.IDX     = 3'd7;
    bus6.LEN     = 4'd0;
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkOutput("dw6_err", 32'(bus6.ERR), 32'd1);
    checkOutput("dw6_vld_after_err", 32'(bus6.SEL_VLD), 32'd0);
    checkOutput("dw6_rdy_after_err", 32'(bus6.IDX_RDY), 32'd1);
    bus6.IDX = 3'd5;
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    bus6.IDX_VLD = 1'b0;
    checkOutput("dw6_err_pulse", 32'(bus6.ERR), 32'd0);
    checkOutput("dw6_sel", 32'(bus6.SEL), 32'h20);
    checkOutput("dw6_last", 32'(bus6.SEL_LAST), 32'd1);
    checkOutput("dw6_vld", 32'(bus6.SEL_VLD), 32'd1);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkOutput("dw6_vld_done", 32'(bus6.SEL_VLD), 32'd0);
    checkOutput("dw6_sel_done", 32'(bus6.SEL), 32'd0);

    // Random traffic with random backpressure, then drain.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
    end
    checkOutput("random_drain", 32'(q.size()), 32'd0);
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/cpm_sel_gen.md
# cpm_sel_gen

Sequential index-to-select generator for the CPM datapath. Accepts a start index and burst length over a valid/ready handshake and emits a stream of one-hot select vectors. The stream walks consecutive lanes with wrap-around and is registered for direct use as lane enables. It is the decode side of the CPM lane-select path: each emitted SEL has exactly one bit set, at the current lane index.

## Interface
Parameters:
- DW, 8, number of select lanes (SEL width), DW ≥ 2
- AW, $clog2(DW), index width
- LW, 4, burst-length field width

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset
- IDX_VLD  input  1  start-index request valid
- IDX_RDY  output  1  generator can accept a request
- IDX  input  AW  start lane index
- LEN  input  LW  burst length minus one (0 → 1 beat, 2^LW−1 → 2^LW beats)
- SEL_VLD  output  1  SEL beat valid
- SEL_RDY  input  1  downstream accepts beat
- SEL  output  DW  one-hot lane select
- SEL_LAST  output  1  current beat is final beat of burst
- ERR  output  1  one-cycle pulse: request rejected (IDX ≥ DW)

## Operation
- Two states:
  - IDLE: IDX_RDY=1, SEL_VLD=0, SEL=0.
  - ISSUE: IDX_RDY=0, SEL_VLD=1.
- Request capture:
  - In IDLE, IDX_VLD=1 with IDX<DW: cur←IDX, cnt←LEN, go to ISSUE.
  - In IDLE, IDX_VLD=1 with IDX≥DW: stay IDLE and pulse ERR next cycle. Only reachable when DW is not a power of 2.
- Beat output in ISSUE:
  - SEL = 1<<cur.
  - SEL_LAST = (cnt==0).
- Beat consumption in ISSUE, on SEL_RDY=1:
  - If cnt==0, go to IDLE.
  - Otherwise cnt←cnt−1 and cur←(cur==DW−1)?0:cur+1, giving modulo-DW wrap.
- Holding: while SEL_VLD=1 and SEL_RDY=0, SEL and SEL_LAST hold stable. No beat is dropped or advanced.
- Bursts longer than DW revisit lanes, e.g. DW=8, IDX=6, LEN=9 yields lanes 6,7,0,…,7.
- Invariants:
  - SEL is either 0 or exactly one-hot.
  - SEL≠0 if and only if SEL_VLD=1.
- Reset (rst_n=0 at an edge):
  - state=IDLE; SEL=0, SEL_VLD=0, SEL_LAST=0, ERR=0; cur=0, cnt=0.
  - IDX_RDY=1 from the first cycle after reset.
  - Reset mid-burst aborts immediately; remaining beats are discarded, with no final SEL_LAST.
- SEL_RDY asserted while SEL_VLD=0 is ignored.

## Timing
- Request accepted at edge N → first SEL_VLD/SEL visible after edge N (cycle N+1); latency 1.
- Throughput: one beat per cycle while SEL_RDY=1. A burst of LEN+1 beats occupies LEN+1 cycles minimum.
- IDX_RDY rises the cycle after the last beat is accepted. This leaves a one-cycle bubble between bursts, so the minimum request period is LEN+2 cycles.
- ERR is high for exactly one cycle, the one following the rejected handshake. IDX_RDY stays 1, so a new request is accepted in that same cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from SEL_RDY or IDX_VLD to any output.
- IDX and LEN are sampled only on the accepting edge. Later changes do not affect the burst in flight.

## Structure
- Shared CPM package holds:
  - the state enum (IDLE, ISSUE);
  - a clog2-based width helper for AW.
- Sub-module cpm_onehot_dec:
  - parameterised DW/AW, combinational;
  - index + enable → one-hot vector; out-of-range index → 0.
  - cpm_sel_gen registers its output.
- The top level contains the FSM, cur/cnt counters and output registers.

## Test plan
- Reset and basic beat: reset, then IDX=3, LEN=0, SEL_RDY=1.
  - After reset: IDX_RDY=1, all other outputs 0.
  - Next cycle: SEL=8'h08, SEL_LAST=1, for exactly one cycle.
  - IDX_RDY=1 the following cycle.
- Wrap: DW=8, IDX=6, LEN=3, SEL_RDY=1 → SEL sequence 0x40, 0x80, 0x01, 0x02; SEL_LAST only on 0x02.
- Backpressure: IDX=1, LEN=2; SEL_RDY low for 3 cycles on beat 2 → SEL=0x04 held stable, then 0x08 with SEL_LAST; total 6 beat-cycles.
- Out-of-range: DW=6, IDX=7 → ERR=1 for one cycle; SEL_VLD stays 0; an immediate IDX=5, LEN=0 request yields SEL=6'b100000.
- Reset mid-burst: IDX=0, LEN=15, rst_n low at beat 4 → SEL=0 and SEL_VLD=0 next cycle; no SEL_LAST; IDX_RDY=1.
- Random stress: random IDX/LEN/SEL_RDY → scoreboard checks SEL one-hot, lane order mod DW, beat count=LEN+1, and stability under backpressure.
